// File: rtl/store_unit_pkg.sv
// rtl/store_unit_pkg.sv - shared encodings for the store unit
// Purpose: store-size codes, FSM state type and byte-lane mask constants
//          shared by store_unit, store_align and the interface users.
// Ports:   none (package).
package store_unit_pkg;

  // store_size_in encodings; 2'b11 is treated as a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Byte-lane write masks, bit i = byte lane i.
  localparam logic [3:0] MASK_NONE    = 4'b0000;
  localparam logic [3:0] MASK_BYTE0   = 4'b0001;
  localparam logic [3:0] MASK_HALF_LO = 4'b0011;
  localparam logic [3:0] MASK_HALF_HI = 4'b1100;
  localparam logic [3:0] MASK_WORD    = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,  // no request outstanding
    ST_WAIT = 1'b1   // request on the port, awaiting dm_ready_in
  } state_t;

endpackage

// File: rtl/store_unit_if.sv
// rtl/store_unit_if.sv - execute-stage and data-memory signals of the store unit
// Purpose: bundles the store handshake from execute and the write port to
//          data memory.
// Ports:   slave modport  = store unit view (store inputs, memory outputs);
//          master modport = execute stage / memory model view.
interface store_unit_if;

  logic        st_valid_in;
  logic        st_ready_out;
  logic [1:0]  store_size_in;
  logic [31:0] iadder_in;
  logic [31:0] rs2_in;
  logic        flush_in;
  logic        dm_wr_req_out;
  logic [31:0] dm_addr_out;
  logic [31:0] dm_data_out;
  logic [3:0]  dm_wr_mask_out;
  logic        dm_ready_in;
  logic        store_done_out;
  logic        misaligned_out;
  logic [31:0] misaligned_addr_out;

  modport slave (
    input  st_valid_in, store_size_in, iadder_in, rs2_in, flush_in, dm_ready_in,
    output st_ready_out, dm_wr_req_out, dm_addr_out, dm_data_out, dm_wr_mask_out,
           store_done_out, misaligned_out, misaligned_addr_out
  );

  modport master (
    output st_valid_in, store_size_in, iadder_in, rs2_in, flush_in, dm_ready_in,
    input  st_ready_out, dm_wr_req_out, dm_addr_out, dm_data_out, dm_wr_mask_out,
           store_done_out, misaligned_out, misaligned_addr_out
  );

endinterface

// File: rtl/store_unit_align.sv
// rtl/store_unit_align.sv - byte-lane placement and alignment check for stores
// Purpose: combinationally replicates rs2 onto the lanes selected by the
//          size and low address bits, builds the write mask and flags
//          misaligned halves/words.
// Ports:   size (2), offset = iadder[1:0] (2), rs2 (32) in;
//          data (32), mask (4), misaligned (1) out.
module store_align
  import store_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] rs2,
  output logic [31:0] data,
  output logic [3:0]  mask,
  output logic        misaligned
);

  always_comb begin
    data       = rs2;
    mask       = MASK_WORD;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        data = {4{rs2[7:0]}};
        mask = MASK_BYTE0 << offset;
      end
      SZ_HALF: begin
        data       = {2{rs2[15:0]}};
        mask       = offset[1] ? MASK_HALF_HI : MASK_HALF_LO;
        misaligned = offset[0];
      end
      default: begin
        misaligned = (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - RV32 data-memory write path with one-entry request register
// Purpose: accepts stores from execute, aligns them via store_align and holds
//          the write request on the data-memory port until accepted.
// Ports:   ms_riscv32_mp_clk_in (1), ms_riscv32_mp_rst_n_in (1, sync active-low);
//          bus (store_unit_if.slave): execute handshake, memory write port,
//          done and misalignment pulses.
module store_unit
  import store_unit_pkg::*;
(
  input  logic          ms_riscv32_mp_clk_in,
  input  logic          ms_riscv32_mp_rst_n_in,
  store_unit_if.slave   bus
);

  state_t      state;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        done;
  logic        mis;
  logic [31:0] mis_addr;

  logic [31:0] al_data;
  logic [3:0]  al_mask;
  logic        al_mis;
  logic        st_ready;
  logic        accept;
  logic        retire;

  store_align u_align (
    .size       (bus.store_size_in),
    .offset     (bus.iadder_in[1:0]),
    .rs2        (bus.rs2_in),
    .data       (al_data),
    .mask       (al_mask),
    .misaligned (al_mis)
  );

  // The only combinational use of dm_ready_in: freeing the register slot in
  // the same cycle the memory takes the current write.
  assign retire   = (state == ST_WAIT) && bus.dm_ready_in;
  assign st_ready = (state == ST_IDLE) || retire;
  assign accept   = bus.st_valid_in && st_ready && !bus.flush_in;

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state    <= ST_IDLE;
      wr_req   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_mask  <= MASK_NONE;
      done     <= 1'b0;
      mis      <= 1'b0;
      mis_addr <= '0;
    end else begin
      done <= retire;
      mis  <= accept && al_mis;
      if (accept && al_mis) begin
        mis_addr <= bus.iadder_in;
      end
      if (accept && !al_mis) begin
        // New aligned store: load the slot (back-to-back when retiring).
        state   <= ST_WAIT;
        wr_req  <= 1'b1;
        wr_addr <= {bus.iadder_in[31:2], 2'b00};
        wr_data <= al_data;
        wr_mask <= al_mask;
      end else if (retire) begin
        // Mask drops with the request; addr/data just keep their last value.
        state   <= ST_IDLE;
        wr_req  <= 1'b0;
        wr_mask <= MASK_NONE;
      end
    end
  end

  assign bus.st_ready_out        = st_ready;
  assign bus.dm_wr_req_out       = wr_req;
  assign bus.dm_addr_out         = wr_addr;
  assign bus.dm_data_out         = wr_data;
  assign bus.dm_wr_mask_out      = wr_mask;
  assign bus.store_done_out      = done;
  assign bus.misaligned_out      = mis;
  assign bus.misaligned_addr_out = mis_addr;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - scoreboard bench for store_unit
module tb_store_unit;
  import store_unit_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_t;

  logic clk;
  logic rst_n;
  store_unit_if bus();

  store_unit dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .bus                    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  wr_t         exp_q[$];
  logic [31:0] mis_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    bus.st_valid_in   = 1'b1;
    bus.store_size_in = size;
    bus.iadder_in     = addr;
    bus.rs2_in        = data;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_t w;
    w.addr = a; w.data = d; w.mask = m;
    exp_q.push_back(w);
  endtask

  // Monitor: compares every memory handshake and misalignment pulse against
  // the queues, and checks the done pulse against last cycle's handshake.
  logic prev_hs = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.store_done_out || prev_hs)
        check("done_pulse", {31'b0, bus.store_done_out}, {31'b0, prev_hs});
      if (!bus.dm_wr_req_out)
        check("idle_mask", {28'b0, bus.dm_wr_mask_out}, 32'h0);
      if (bus.dm_wr_req_out && bus.dm_ready_in) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'h1, 32'h0);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          check("wr_addr", bus.dm_addr_out, w.addr);
          check("wr_data", bus.dm_data_out, w.data);
          check("wr_mask", {28'b0, bus.dm_wr_mask_out}, {28'b0, w.mask});
        end
      end
      if (bus.misaligned_out) begin
        if (mis_q.size() == 0) check("unexpected_misaligned", 32'h1, 32'h0);
        else check("mis_addr", bus.misaligned_addr_out, mis_q.pop_front());
      end
    end
    prev_hs = rst_n && bus.dm_wr_req_out && bus.dm_ready_in;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n             = 1'b0;
    bus.st_valid_in   = 1'b0;
    bus.store_size_in = SZ_WORD;
    bus.iadder_in     = '0;
    bus.rs2_in        = '0;
    bus.flush_in      = 1'b0;
    bus.dm_ready_in   = 1'b0;
    cyc(); cyc();
    check("rst_req",     {31'b0, bus.dm_wr_req_out}, 32'h0);
    check("rst_mask",    {28'b0, bus.dm_wr_mask_out}, 32'h0);
    check("rst_addr",    bus.dm_addr_out, 32'h0);
    check("rst_data",    bus.dm_data_out, 32'h0);
    check("rst_done",    {31'b0, bus.store_done_out}, 32'h0);
    check("rst_mis",     {31'b0, bus.misaligned_out}, 32'h0);
    check("rst_misaddr", bus.misaligned_addr_out, 32'h0);
    check("rst_ready",   {31'b0, bus.st_ready_out}, 32'h1);
    rst_n = 1'b1;
    cyc();

    // Byte store to lane 3, memory ready immediately.
    bus.dm_ready_in = 1'b1;
    present(SZ_BYTE, 32'h0000_1003, 32'h0000_00A5);
    push_wr(32'h0000_1000, 32'hA5A5_A5A5, 4'b1000);
    cyc();
    bus.st_valid_in = 1'b0;
    check("byte_req", {31'b0, bus.dm_wr_req_out}, 32'h1);
    cyc();
    check("byte_done", {31'b0, bus.store_done_out}, 32'h1);
    check("byte_req_drop", {31'b0, bus.dm_wr_req_out}, 32'h0);

    // Upper half store, memory stalls for three cycles.
    bus.dm_ready_in = 1'b0;
    present(SZ_HALF, 32'h0000_2002, 32'h1234_BEEF);
    push_wr(32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
    cyc();
    bus.st_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("half_hold_data", bus.dm_data_out, 32'hBEEF_BEEF);
      check("half_hold_mask", {28'b0, bus.dm_wr_mask_out}, 32'hC);
      check("half_hold_req",  {31'b0, bus.dm_wr_req_out}, 32'h1);
      check("half_stall_rdy", {31'b0, bus.st_ready_out}, 32'h0);
      cyc();
    end
    bus.dm_ready_in = 1'b1;
    #1;
    check("half_rdy_on_ack", {31'b0, bus.st_ready_out}, 32'h1);
    check("half_hold_data4", bus.dm_data_out, 32'hBEEF_BEEF);
    cyc();
    check("half_done", {31'b0, bus.store_done_out}, 32'h1);

    // Misaligned word and half: no bus request, fault pulse instead.
    present(SZ_WORD, 32'h0000_3001, 32'hDEAD_BEEF);
    mis_q.push_back(32'h0000_3001);
    cyc();
    bus.st_valid_in = 1'b0;
    check("misw_req", {31'b0, bus.dm_wr_req_out}, 32'h0);
    check("misw_pulse", {31'b0, bus.misaligned_out}, 32'h1);
    present(SZ_HALF, 32'h0000_3003, 32'h0000_5555);
    mis_q.push_back(32'h0000_3003);
    cyc();
    bus.st_valid_in = 1'b0;
    check("mish_req", {31'b0, bus.dm_wr_req_out}, 32'h0);
    check("mish_pulse", {31'b0, bus.misaligned_out}, 32'h1);
    cyc();
    check("mis_pulse_end", {31'b0, bus.misaligned_out}, 32'h0);

    // Four back-to-back aligned words at full throughput.
    for (int i = 0; i < 4; i++) begin
      present(SZ_WORD, 32'h0000_4000 + 32'(i * 4), 32'h1111_1111 * 32'(i + 1));
      push_wr(32'h0000_4000 + 32'(i * 4), 32'h1111_1111 * 32'(i + 1), 4'b1111);
      #1;
      check("b2b_ready", {31'b0, bus.st_ready_out}, 32'h1);
      cyc();
      check("b2b_req", {31'b0, bus.dm_wr_req_out}, 32'h1);
    end
    bus.st_valid_in = 1'b0;
    cyc();
    check("b2b_req_drop", {31'b0, bus.dm_wr_req_out}, 32'h0);
    cyc();

    // Flush in IDLE blocks acceptance.
    bus.flush_in = 1'b1;
    present(SZ_WORD, 32'h0000_5000, 32'h5050_5050);
    cyc();
    bus.st_valid_in = 1'b0;
    bus.flush_in    = 1'b0;
    check("flush_idle_req", {31'b0, bus.dm_wr_req_out}, 32'h0);
    // Flush while a write waits does not cancel it.
    bus.dm_ready_in = 1'b0;
    present(SZ_BYTE, 32'h0000_6001, 32'h0000_0077);
    push_wr(32'h0000_6000, 32'h7777_7777, 4'b0010);
    cyc();
    bus.st_valid_in = 1'b0;
    bus.flush_in    = 1'b1;
    cyc();
    bus.flush_in = 1'b0;
    check("flush_wait_req", {31'b0, bus.dm_wr_req_out}, 32'h1);
    bus.dm_ready_in = 1'b1;
    cyc();
    check("flush_wait_done", {31'b0, bus.store_done_out}, 32'h1);

    // Reset during WAIT drops the request with no done pulse.
    bus.dm_ready_in = 1'b0;
    present(SZ_WORD, 32'h0000_7000, 32'h7000_0007);
    push_wr(32'h0000_7000, 32'h7000_0007, 4'b1111);
    cyc();
    bus.st_valid_in = 1'b0;
    check("rstw_req_before", {31'b0, bus.dm_wr_req_out}, 32'h1);
    rst_n = 1'b0;
    cyc();
    exp_q.delete();
    check("rstw_req",   {31'b0, bus.dm_wr_req_out}, 32'h0);
    check("rstw_mask",  {28'b0, bus.dm_wr_mask_out}, 32'h0);
    check("rstw_done",  {31'b0, bus.store_done_out}, 32'h0);
    check("rstw_ready", {31'b0, bus.st_ready_out}, 32'h1);
    rst_n = 1'b1;
    cyc();
    check("rstw_done_after", {31'b0, bus.store_done_out}, 32'h0);
    cyc(); cyc();

    check("exp_q_drained", exp_q.size(), 32'h0);
    check("mis_q_drained", mis_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/store_unit.md
# store_unit

Data-memory write path of the RV32 core: takes store requests from the execute stage, checks alignment, places the rs2 byte/half/word on the correct lanes with a matching write mask, and holds a write request on the data-memory port until the memory accepts it. It sits beside the load alignment unit on the same data-memory interface and is its write-direction counterpart. A one-entry request register lets the pipeline issue back-to-back stores without bubbles when memory is ready every cycle.

## Interface
- Parameters: none.
- ms_riscv32_mp_clk_in  input  1  core clock; all state changes on rising edge.
- ms_riscv32_mp_rst_n_in  input  1  reset, synchronous, active-low.
- st_valid_in  input  1  execute stage presents a store this cycle.
- st_ready_out  output  1  store unit accepts the presented store this cycle.
- store_size_in  input  2  00 byte, 01 half, 10/11 word.
- iadder_in  input  32  effective byte address.
- rs2_in  input  32  store data, value right-justified.
- flush_in  input  1  pipeline flush; blocks acceptance this cycle.
- dm_wr_req_out  output  1  write request to data memory.
- dm_addr_out  output  32  word address, {iadder[31:2], 2'b00}.
- dm_data_out  output  32  lane-placed write data.
- dm_wr_mask_out  output  4  byte enables, bit i = byte lane i.
- dm_ready_in  input  1  memory accepts the current request this cycle.
- store_done_out  output  1  one-cycle pulse after a write is accepted.
- misaligned_out  output  1  one-cycle pulse: accepted store was misaligned.
- misaligned_addr_out  output  32  faulting byte address, valid with misaligned_out.

## Operation
- States: IDLE (no request outstanding), WAIT (request on port, awaiting dm_ready_in).
- Accept = st_valid_in & st_ready_out & ~flush_in.
- st_ready_out = (state==IDLE) | (state==WAIT & dm_ready_in); combinational.
- Alignment: byte always aligned; half misaligned if iadder[0]; word misaligned if iadder[1:0]!=0.
- Lane placement: byte: data = {4{rs2[7:0]}}, mask = 4'b0001 << iadder[1:0]; half: data = {2{rs2[15:0]}}, mask = iadder[1] ? 4'b1100 : 4'b0011; word: data = rs2, mask = 4'b1111.
- Aligned accept: register addr/data/mask, enter/stay in WAIT, dm_wr_req_out=1 next cycle.
- Misaligned accept: no bus request; misaligned_out=1 and misaligned_addr_out=iadder next cycle; state unchanged by it (IDLE, or IDLE after a completing WAIT).
- WAIT & dm_ready_in & no accept: go IDLE, dm_wr_req_out=0 next cycle.
- WAIT & dm_ready_in & aligned accept: stay WAIT, load new request (back-to-back).
- In WAIT without dm_ready_in: dm_addr_out/dm_data_out/dm_wr_mask_out/dm_wr_req_out held stable.
- flush_in never cancels a request already on the port; it only suppresses acceptance in its cycle.
- store_done_out = registered (state==WAIT & dm_ready_in).

## Timing
- Reset (rst_n low at a clock edge): state IDLE; dm_wr_req_out, store_done_out, misaligned_out = 0; dm_addr_out, dm_data_out, misaligned_addr_out = 0; dm_wr_mask_out = 4'b0000. Reset mid-WAIT drops the request with no done pulse.
- Latency: accept in cycle N -> dm_wr_req_out high in N+1; dm_ready_in high in cycle M -> store_done_out high in M+1.
- Throughput: one store per cycle while dm_ready_in stays high.
- dm_wr_mask_out is 0 whenever dm_wr_req_out is 0.
- No combinational path from dm_ready_in to dm_* outputs; only st_ready_out depends on it.

## Structure
- Shared package: store-size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state enum, lane-mask constants.
- Sub-module store_align: combinational placement of data/mask and misalignment flag from size, iadder[1:0], rs2; the top holds FSM and output registers.

## Test plan
- Byte store, iadder=0x1003, rs2=0x000000A5, dm_ready_in=1 -> next cycle addr 0x1000, data 0xA5A5A5A5, mask 1000, req=1; done pulse one cycle later.
- Half store, iadder=0x2002, rs2=0x1234BEEF, dm_ready_in low 3 cycles -> mask 1100, data 0xBEEFBEEF held stable 4 cycles, st_ready_out=0 until ready.
- Word store iadder=0x3001 -> no req, misaligned_out pulse, misaligned_addr_out=0x3001; half at 0x3003 likewise.
- Four back-to-back word stores, dm_ready_in=1 always -> req high 4 consecutive cycles, 4 done pulses, st_ready_out never low.
- flush_in with st_valid_in in IDLE -> no request; flush_in during WAIT -> pending write still completes.
- rst_n low during WAIT -> next cycle req=0, mask=0000, no done pulse, state IDLE.
